pixel_window_sequencer: RTL and testbench
=========================================

# pixel_window_sequencer

Streaming controller that sequences the camera pixel stream into 3x3 neighbourhood windows for the per-pixel edge-resolve stage. It accepts raster-order 12-bit RGB444 pixels from the capture path and holds the two previous rows in line buffers. Each cycle it presents at most one complete window (nine pixels plus centre coordinates) with a valid strobe. It also flushes the right-most column and bottom row during blanking, so every pixel of the frame receives exactly one window.

## Interface
- IMG_WIDTH, 640, pixels per row (≥3, ≤1024)
- IMG_HEIGHT, 480, rows per frame (≥3, ≤512)
- clk25  in  1  pixel clock; all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- pixIn  in  12  RGB444 input pixel {R[11:8],G[7:4],B[3:0]}
- pixValid  in  1  pixIn valid this cycle
- frameStart  in  1  high with first pixel of a frame (qualified by pixValid)
- win_lu, win_mu, win_ru, win_lm, win_mm, win_rm, win_ld, win_md, win_rd  out  12 each  window pixels; l/m/r = column x-1/x/x+1, u/m/d = row y-1/y/y+1
- xAddr  out  10  centre column of presented window
- yAddr  out  9  centre row of presented window
- winValid  out  1  window outputs valid this cycle
- frameDone  out  1  one-cycle pulse with last window of a frame (centre W-1,H-1)
- overrun  out  1  sticky: pixel arrived while sequencer could not accept it; cleared by rst or frameStart

## Operation
- Counters: inX (0..W-1), inY (0..H-1) track the next input pixel position; advance only on accepted pixValid.
- Line buffers: lineA holds row inY-1, lineB holds row inY-2. Each is a single-port W×12 RAM. At address inX, read first, then write: lineB←lineA[inX], lineA←pixIn.
- Column shift registers: three 3-deep registers (up/mid/down rows). Each accepted pixel shifts in {lineB[inX], lineA[inX], pixIn}.
- Window rule: an accepted pixel at (inX,inY) with inX≥1 and inY≥1 emits the window centred at (inX-1, inY-1).
- Out-of-image neighbours read as 12'h000:
  - column -1 at xAddr=0; column W at xAddr=W-1;
  - row -1 at yAddr=0; row H at yAddr=H-1.
- FSM states:
  - IDLE: wait for frameStart&pixValid; accept that pixel as (0,0), go to FILL.
  - FILL: rows 0 (no windows emitted); at end of row 0 go to STREAM.
  - STREAM: emit per window rule. After the pixel at inX=W-1 (inY≥1), go to ROW_FLUSH.
  - ROW_FLUSH: exactly one cycle, no input accepted. Emits centre (W-1, inY-1) with right column zero. Next state is STREAM, or FRAME_FLUSH if that row was H-1.
  - FRAME_FLUSH: W cycles, internal column counter fx=0..W-1, no input accepted.
    - Reads lineA (row H-1) as mid row and lineB (row H-2) as up row; down row zero.
    - Emits centres (fx, H-1); frameDone with fx=W-1; then go to IDLE.
- Input rules:
  - pixValid during ROW_FLUSH or FRAME_FLUSH: pixel dropped, overrun set.
  - Source guarantees ≥1 blank cycle per row and ≥W+1 blank cycles before the next frameStart.
- frameStart&pixValid in any state: abort the current frame, discard pending flushes, clear overrun, take the pixel as (0,0), enter FILL. No frameDone for the aborted frame.
- pixValid in IDLE without frameStart: ignored, no overrun.

## Timing
- Reset: all window outputs 12'h000, xAddr=0, yAddr=0, winValid=0, frameDone=0, overrun=0, state IDLE, counters 0. Line buffer contents are don't-care: FILL rewrites them before use.
- Latency: winValid and window data are registered, asserted on the cycle after the triggering accepted pixel (or flush cycle).
- Throughput: one window per cycle maximum. Windows per frame = W×H exactly, in raster order of centre.
- Out-of-image zero substitution is applied in the output register stage, not in the buffers.
- Mid-operation reset: outputs return to reset values asynchronously; no further windows until the next frameStart.

## Test plan
- W=4, H=3, pixel value = {y[3:0],x[3:0],4'h0}, 1 blank cycle/row, 8 blank cycles at end:
  - exactly 12 winValid pulses, centres (0,0)…(3,2) in raster order;
  - window (1,1) has win_mm=12'h110, win_lu=12'h000+… = 12'h000, win_rd=12'h220;
  - frameDone coincides with centre (3,2).
- Boundary zeros:
  - window (0,0): win_lu, win_mu, win_ru, win_lm, win_ld = 12'h000; win_mm=12'h000; win_rm=12'h010; win_md=12'h100.
  - window (3,2): win_ru, win_rm, win_rd, win_ld, win_md = 12'h000.
- Gapped input: random pixValid gaps inside rows produce an identical window sequence and values; xAddr/yAddr are unaffected by gaps.
- Overrun: pixValid asserted in the ROW_FLUSH cycle → overrun=1 and stays set; a following frameStart clears it to 0.
- Abort: frameStart mid-row 1 → no frameDone for the aborted frame; the new frame produces 12 correct windows.
- Async reset asserted during FRAME_FLUSH → winValid=0 and all outputs 0 immediately; IDLE; pixValid without frameStart emits nothing.

Source files
------------

// File: rtl/pixel_window_sequencer.sv
// pixel_window_sequencer
// Turns a raster RGB444 pixel stream into 3x3 neighbourhood windows, one per
// pixel of the frame. Two line buffers hold the previous rows. The right-most
// column and the bottom row are flushed during blanking.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | waiting for frameStart with pixValid
// FILL        | receiving row 0, no windows yet
// STREAM      | receiving rows 1..H-1, one window per accepted pixel (x>=1)
// ROW_FLUSH   | one cycle after each row: emits the last column of row y-1
// FRAME_FLUSH | W cycles after the last row: emits the bottom row from buffers
module pixel_window_sequencer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic [11:0] pixIn,
  input  logic        pixValid,
  input  logic        frameStart,
  output logic [11:0] win_lu,
  output logic [11:0] win_mu,
  output logic [11:0] win_ru,
  output logic [11:0] win_lm,
  output logic [11:0] win_mm,
  output logic [11:0] win_rm,
  output logic [11:0] win_ld,
  output logic [11:0] win_md,
  output logic [11:0] win_rd,
  output logic [9:0]  xAddr,
  output logic [8:0]  yAddr,
  output logic        winValid,
  output logic        frameDone,
  output logic        overrun
);

  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [9:0] X_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    STREAM,
    ROW_FLUSH,
    FRAME_FLUSH
  } state_t;

  state_t state, stateNext;

  logic [9:0]  inX;
  logic [8:0]  inY;
  logic [9:0]  fx;
  logic [8:0]  flushY;
  logic        flushLast;

  logic [11:0] lineA [IMG_WIDTH];
  logic [11:0] lineB [IMG_WIDTH];
  logic [AW-1:0] rdAddr;
  logic [11:0] rdA;
  logic [11:0] rdB;

  // Column shift taps: index 0 is column x-1 of the window, index 1 is x-2.
  // The freshly read column (rdB, rdA, pixIn) acts as the third tap.
  logic [11:0] srU0, srU1, srM0, srM1, srD0, srD1;

  logic        start;
  logic        accept;
  logic        rowEnd;
  logic        emit;
  logic        done;
  logic [9:0]  emitX;
  logic [8:0]  emitY;
  logic        zl, zr, zu, zd;

  assign start  = pixValid & frameStart;
  assign accept = start | (pixValid & ((state == FILL) | (state == STREAM)));
  assign rowEnd = (inX == X_LAST);

  assign rdA = lineA[rdAddr];
  assign rdB = lineB[rdAddr];

  assign zl = (emitX == 10'd0);
  assign zr = (emitX == X_LAST);
  assign zu = (emitY == 9'd0);
  assign zd = (emitY == Y_LAST);

  // State register
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic; a qualified frameStart restarts from any state
  always_comb begin
    stateNext = state;
    if (start) begin
      stateNext = FILL;
    end else begin
      case (state)
        FILL:        if (accept && rowEnd) stateNext = STREAM;
        STREAM:      if (accept && rowEnd) stateNext = ROW_FLUSH;
        ROW_FLUSH:   stateNext = flushLast ? FRAME_FLUSH : STREAM;
        FRAME_FLUSH: if (fx == X_LAST) stateNext = IDLE;
        default:     stateNext = state;
      endcase
    end
  end

  // Output decode: buffer read address, window emit strobe and centre
  always_comb begin
    rdAddr = inX[AW-1:0];
    emit   = 1'b0;
    done   = 1'b0;
    emitX  = inX - 10'd1;
    emitY  = inY - 9'd1;
    if (start) begin
      rdAddr = '0;
    end else begin
      case (state)
        STREAM: emit = accept && (inX != 10'd0);
        ROW_FLUSH: begin
          // Column 0 is preloaded here in case the bottom-row flush follows.
          rdAddr = '0;
          emit   = 1'b1;
          emitX  = X_LAST;
          emitY  = flushY;
        end
        FRAME_FLUSH: begin
          // Read one column ahead so the right neighbour is available.
          rdAddr = (fx == X_LAST) ? '0 : (fx[AW-1:0] + AW'(1));
          emit   = 1'b1;
          emitX  = fx;
          emitY  = Y_LAST;
          done   = (fx == X_LAST);
        end
        default: emit = 1'b0;
      endcase
    end
  end

  // Line buffers: read-before-write at the same address on each accepted pixel
  always_ff @(posedge clk25) begin
    if (accept) begin
      lineB[rdAddr] <= rdA;
      lineA[rdAddr] <= pixIn;
    end
  end

  // Input position counters, flush bookkeeping and sticky overrun
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      inX       <= '0;
      inY       <= '0;
      fx        <= '0;
      flushY    <= '0;
      flushLast <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (start) begin
        inX <= 10'd1;
        inY <= '0;
      end else if (accept) begin
        if (rowEnd) begin
          inX       <= '0;
          inY       <= (inY == Y_LAST) ? 9'd0 : inY + 9'd1;
          flushY    <= inY - 9'd1;
          flushLast <= (inY == Y_LAST);
        end else begin
          inX <= inX + 10'd1;
        end
      end
      fx <= (state == FRAME_FLUSH && !start && fx != X_LAST) ? fx + 10'd1 : 10'd0;
      if (start)
        overrun <= 1'b0;
      else if (pixValid && (state == ROW_FLUSH || state == FRAME_FLUSH))
        overrun <= 1'b1;
    end
  end

  // Column shift registers; the row flush reloads column 0 with column -1 zero
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      srU0 <= '0; srU1 <= '0;
      srM0 <= '0; srM1 <= '0;
      srD0 <= '0; srD1 <= '0;
    end else if (accept) begin
      srU1 <= srU0; srU0 <= rdB;
      srM1 <= srM0; srM0 <= rdA;
      srD1 <= srD0; srD0 <= pixIn;
    end else if (state == ROW_FLUSH) begin
      srU1 <= '0; srU0 <= rdB;
      srM1 <= '0; srM0 <= rdA;
      srD1 <= '0; srD0 <= '0;
    end else if (state == FRAME_FLUSH) begin
      srU1 <= srU0; srU0 <= rdB;
      srM1 <= srM0; srM0 <= rdA;
      srD1 <= srD0; srD0 <= '0;
    end
  end

  // Registered window outputs with out-of-image neighbours forced to zero
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      winValid  <= 1'b0;
      frameDone <= 1'b0;
      xAddr     <= '0;
      yAddr     <= '0;
      win_lu <= '0; win_mu <= '0; win_ru <= '0;
      win_lm <= '0; win_mm <= '0; win_rm <= '0;
      win_ld <= '0; win_md <= '0; win_rd <= '0;
    end else begin
      winValid  <= emit;
      frameDone <= done;
      if (emit) begin
        xAddr  <= emitX;
        yAddr  <= emitY;
        win_lu <= (zl | zu) ? 12'h000 : srU1;
        win_mu <= zu        ? 12'h000 : srU0;
        win_ru <= (zr | zu) ? 12'h000 : rdB;
        win_lm <= zl        ? 12'h000 : srM1;
        win_mm <= srM0;
        win_rm <= zr        ? 12'h000 : rdA;
        win_ld <= (zl | zd) ? 12'h000 : srD1;
        win_md <= zd        ? 12'h000 : srD0;
        win_rd <= (zr | zd) ? 12'h000 : pixIn;
      end
    end
  end

endmodule

// File: tb/tb_pixel_window_sequencer.sv
// Testbench for pixel_window_sequencer on a 4x3 image. Expected windows are
// derived from the image itself and queued as frames are issued; a monitor
// thread pops and compares one entry per winValid.
module tb_pixel_window_sequencer;

  localparam int W = 4;
  localparam int H = 3;

  logic        clk25 = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] pixIn = 12'h000;
  logic        pixValid = 1'b0;
  logic        frameStart = 1'b0;
  logic [11:0] win_lu, win_mu, win_ru, win_lm, win_mm, win_rm, win_ld, win_md, win_rd;
  logic [9:0]  xAddr;
  logic [8:0]  yAddr;
  logic        winValid, frameDone, overrun;

  typedef struct packed {
    logic [9:0]   x;
    logic [8:0]   y;
    logic [107:0] p;
    logic         done;
  } win_t;

  win_t expQ[$];
  int   checks = 0;
  int   passes = 0;
  int   doneCount = 0;
  int   expDone = 0;

  pixel_window_sequencer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk25(clk25), .rst(rst), .pixIn(pixIn), .pixValid(pixValid), .frameStart(frameStart),
    .win_lu(win_lu), .win_mu(win_mu), .win_ru(win_ru),
    .win_lm(win_lm), .win_mm(win_mm), .win_rm(win_rm),
    .win_ld(win_ld), .win_md(win_md), .win_rd(win_rd),
    .xAddr(xAddr), .yAddr(yAddr), .winValid(winValid), .frameDone(frameDone), .overrun(overrun)
  );

  always #5 clk25 = ~clk25;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [11:0] pv(int x, int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 12'h000;
    return {y[3:0], x[3:0], 4'h0};
  endfunction

  function automatic win_t mkWin(int x, int y);
    win_t w;
    w.x = 10'(x);
    w.y = 9'(y);
    w.p = {pv(x-1, y-1), pv(x, y-1), pv(x+1, y-1),
           pv(x-1, y),   pv(x, y),   pv(x+1, y),
           pv(x-1, y+1), pv(x, y+1), pv(x+1, y+1)};
    w.done = (x == W-1) && (y == H-1);
    return w;
  endfunction

  task automatic pushWindows(int n);
    for (int i = 0; i < n; i++) expQ.push_back(mkWin(i % W, i / W));
  endtask

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic sendPixel(int x, int y, logic fs);
    @(posedge clk25); #1;
    pixValid = 1'b1; frameStart = fs; pixIn = pv(x, y);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk25); #1;
      pixValid = 1'b0; frameStart = 1'b0; pixIn = 12'h000;
    end
  endtask

  // junkSlotRow >= 0 replaces the blank after that row with a stray pixel
  task automatic sendFrame(bit gaps, int junkSlotRow);
    pushWindows(W * H);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (gaps && x > 0 && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        sendPixel(x, y, (x == 0 && y == 0));
      end
      if (y == junkSlotRow) begin
        @(posedge clk25); #1;
        pixValid = 1'b1; frameStart = 1'b0; pixIn = 12'hfff;
      end else begin
        idle(1);
      end
    end
    idle(8);
  endtask

  task automatic checkOutputsZero(string tag);
    chk({tag, "_window"}, {20'h0, win_lu, win_mu, win_ru, win_lm, win_mm, win_rm, win_ld, win_md, win_rd}, 128'h0);
    chk({tag, "_ctrl"}, {106'h0, xAddr, yAddr, winValid, frameDone, overrun}, 128'h0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk25);
        if (frameDone) doneCount++;
        if (frameDone && !winValid) begin
          checks++;
          $display("FAIL frameDone_without_window: frameDone=1 winValid=0 expected winValid=1");
        end
        if (winValid) begin
          win_t got, e;
          got = {xAddr, yAddr, win_lu, win_mu, win_ru, win_lm, win_mm, win_rm,
                 win_ld, win_md, win_rd, frameDone};
          checks++;
          if (expQ.size() == 0) begin
            $display("FAIL unexpected_window: got x=%0d y=%0d with none expected", xAddr, yAddr);
          end else begin
            e = expQ.pop_front();
            if (got === e) passes++;
            else $display("FAIL window: got x=%0d y=%0d p=%h done=%b expected x=%0d y=%0d p=%h done=%b",
                          got.x, got.y, got.p, got.done, e.x, e.y, e.p, e.done);
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk25);
    #1;
    checkOutputsZero("reset");
    @(negedge clk25);
    rst = 1'b0;

    // Plain frame, then a frame with random gaps inside the rows
    sendFrame(1'b0, -1); expDone++;
    sendFrame(1'b1, -1); expDone++;
    chk("overrun_clean", {127'h0, overrun}, 128'h0);

    // Stray pixel in the ROW_FLUSH slot after row 1
    sendFrame(1'b0, 1); expDone++;
    chk("overrun_sticky", {127'h0, overrun}, 128'h1);
    sendFrame(1'b0, -1); expDone++;
    chk("overrun_cleared", {127'h0, overrun}, 128'h0);

    // Abort mid-row 1: only windows (0,0) and (1,0) come from the old frame
    pushWindows(2);
    for (int x = 0; x < W; x++) sendPixel(x, 0, (x == 0));
    idle(1);
    for (int x = 0; x < 3; x++) sendPixel(x, 1, 1'b0);
    sendFrame(1'b0, -1); expDone++;

    // Reset during FRAME_FLUSH right after window (0,2) is presented
    pushWindows(W + W + 1);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) sendPixel(x, y, (x == 0 && y == 0));
      if (y < H-1) idle(1);
    end
    idle(1);
    @(posedge clk25);
    @(posedge clk25);
    @(negedge clk25);
    #1 rst = 1'b1;
    #1;
    checkOutputsZero("midreset");
    repeat (2) @(posedge clk25);
    @(negedge clk25);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) sendPixel(i + 1, 0, 1'b0);
    idle(6);
    chk("idle_no_overrun", {127'h0, overrun}, 128'h0);

    // Recovery frame after reset
    sendFrame(1'b0, -1); expDone++;

    repeat (4) @(posedge clk25);
    @(negedge clk25);
    #1;
    chk("queue_drained", 128'(expQ.size()), 128'h0);
    chk("frameDone_count", 128'(doneCount), 128'(expDone));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
